// File: rtl/ring_pattern_gen.sv
// Rotating / shifting / bouncing / Johnson pattern generator with a step-rate prescaler.
// Latency: 1 clock from a tick or load to the updated pattern; pattern output is combinational.
// Backpressure: none; run=0 freezes both the pattern and the prescaler in place.
module ring_pattern_gen #(
    parameter int               WIDTH      = 8,
    parameter int               PRESCALE_W = 4,
    parameter logic [WIDTH-1:0] RESET_VAL  = WIDTH'(1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_data,
    input  logic                  run,
    input  logic                  dir,
    input  logic [1:0]            mode,
    input  logic [PRESCALE_W-1:0] rate,
    input  logic                  mirror,
    output logic [WIDTH-1:0]      pattern,
    output logic                  step,
    output logic                  wrap
);

    localparam logic [1:0] MODE_ROT = 2'b00;
    localparam logic [1:0] MODE_SHF = 2'b01;
    localparam logic [1:0] MODE_BNC = 2'b10;
    localparam logic [1:0] MODE_JOH = 2'b11;

    logic [WIDTH-1:0]      preg;
    logic [WIDTH-1:0]      seed;
    logic [PRESCALE_W-1:0] cnt;
    logic                  bdir;

    logic                  tick;
    logic [WIDTH-1:0]      nxt;
    logic                  nbdir;
    logic                  lead;

    // d=0 moves toward the MSB and fills bit 0; d=1 moves toward the LSB and fills the MSB.
    function automatic logic [WIDTH-1:0] shift_fill(input logic [WIDTH-1:0] v,
                                                    input logic d,
                                                    input logic fill);
        return d ? {fill, v[WIDTH-1:1]} : {v[WIDTH-2:0], fill};
    endfunction

    assign tick = run && (cnt == rate);

    // Candidate next pattern and bounce direction for the current mode.
    always_comb begin
        nxt   = preg;
        nbdir = bdir;
        lead  = bdir ? preg[0] : preg[WIDTH-1];
        case (mode)
            MODE_ROT: nxt = shift_fill(preg, dir, dir ? preg[0] : preg[WIDTH-1]);
            MODE_SHF: nxt = shift_fill(preg, dir, 1'b0);
            MODE_JOH: nxt = shift_fill(preg, dir, dir ? ~preg[0] : ~preg[WIDTH-1]);
            MODE_BNC: begin
                // A set bit at the leading edge reverses travel before shifting;
                // an all-zero pattern never has a leading bit, so it stays put.
                nbdir = lead ? ~bdir : bdir;
                nxt   = shift_fill(preg, nbdir, 1'b0);
            end
            default: nxt = preg;
        endcase
    end

    // State update: reset beats load, load beats tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            preg <= RESET_VAL;
            seed <= RESET_VAL;
            cnt  <= '0;
            bdir <= 1'b0;
            step <= 1'b0;
            wrap <= 1'b0;
        end else if (load) begin
            preg <= load_data;
            seed <= load_data;
            cnt  <= '0;
            bdir <= dir;
            step <= 1'b0;
            wrap <= 1'b0;
        end else begin
            step <= tick;
            wrap <= tick && (nxt == seed);
            if (tick) begin
                preg <= nxt;
                cnt  <= '0;
            end else if (run) begin
                cnt  <= cnt + PRESCALE_W'(1);
            end
            // Bounce keeps its own travel direction; other modes track dir directly.
            if (mode != MODE_BNC) begin
                bdir <= dir;
            end else if (tick) begin
                bdir <= nbdir;
            end
        end
    end

    // Optional bit reversal on the way out, no register stage.
    always_comb begin
        pattern = preg;
        if (mirror) begin
            for (int i = 0; i < WIDTH; i++) begin
                pattern[i] = preg[WIDTH-1-i];
            end
        end
    end

endmodule

// File: tb/tb_ring_pattern_gen.sv
// Directed checks of ring_pattern_gen: reset, mirror, all four modes, prescaler hold, load/reset priority.
// Latency: expectations are sampled 1 ns after each rising edge.
// Backpressure: not applicable; stimulus is driven on fixed cycle counts only.
module tb_ring_pattern_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [7:0] load_data;
    logic       run;
    logic       dir;
    logic [1:0] mode;
    logic [3:0] rate;
    logic       mirror;
    logic [7:0] pattern;
    logic       step;
    logic       wrap;

    int checks = 0;
    int errors = 0;

    ring_pattern_gen #(
        .WIDTH      (8),
        .PRESCALE_W (4),
        .RESET_VAL  (8'h01)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (load_data),
        .run       (run),
        .dir       (dir),
        .mode      (mode),
        .rate      (rate),
        .mirror    (mirror),
        .pattern   (pattern),
        .step      (step),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock, then compare all three outputs.
    task automatic cyc(input string tag, input logic [7:0] exp_pat,
                       input logic exp_step, input logic exp_wrap);
        @(posedge clk);
        #1;
        check({tag, " pattern"}, {24'h0, pattern}, {24'h0, exp_pat});
        check({tag, " step"},    {31'h0, step},    {31'h0, exp_step});
        check({tag, " wrap"},    {31'h0, wrap},    {31'h0, exp_wrap});
    endtask

    logic [7:0] rot_exp [8]  = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};
    logic [7:0] bnc_exp [16] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                                 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
    logic [7:0] joh_exp [16] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
    logic [7:0] shr_exp [7]  = '{8'h48, 8'h24, 8'h12, 8'h09, 8'h04, 8'h02, 8'h01};

    initial begin
        rst = 1'b1; load = 1'b0; load_data = 8'h00; run = 1'b0;
        dir = 1'b0; mode = 2'b00; rate = 4'd0; mirror = 1'b0;

        // Reset and mirror
        cyc("reset", 8'h01, 1'b0, 1'b0);
        rst = 1'b0;
        mirror = 1'b1;
        #1;
        check("mirror reset", {24'h0, pattern}, 32'h80);
        mirror = 1'b0;

        // Rotate left from 0x81, one advance per cycle, wraps on the 8th
        load = 1'b1; load_data = 8'h81; run = 1'b1; mode = 2'b00; dir = 1'b0; rate = 4'd0;
        cyc("rot load", 8'h81, 1'b0, 1'b0);
        load = 1'b0;
        for (int i = 0; i < 8; i++) cyc("rot", rot_exp[i], 1'b1, (i == 7));

        // Prescaler: rate=3 gives one advance every 4 cycles
        load = 1'b1; load_data = 8'h01; rate = 4'd3;
        cyc("pre load", 8'h01, 1'b0, 1'b0);
        load = 1'b0;
        for (int i = 0; i < 8; i++)
            cyc("pre", (i < 3) ? 8'h01 : (i < 7) ? 8'h02 : 8'h04, (i == 3) || (i == 7), 1'b0);
        cyc("pre c1", 8'h04, 1'b0, 1'b0);
        cyc("pre c2", 8'h04, 1'b0, 1'b0);
        // Freeze with cnt=2, then resume: one more count then the tick
        run = 1'b0;
        for (int i = 0; i < 5; i++) cyc("hold", 8'h04, 1'b0, 1'b0);
        run = 1'b1;
        cyc("resume c3", 8'h04, 1'b0, 1'b0);
        cyc("resume tick", 8'h08, 1'b1, 1'b0);

        // Bounce from 0x01, wraps when it returns to the seed
        load = 1'b1; load_data = 8'h01; rate = 4'd0; mode = 2'b10; dir = 1'b0;
        cyc("bnc load", 8'h01, 1'b0, 1'b0);
        load = 1'b0;
        for (int i = 0; i < 16; i++) cyc("bnc", bnc_exp[i], 1'b1, (i == 13));

        // Johnson from 0x00, 16-state cycle
        load = 1'b1; load_data = 8'h00; mode = 2'b11; dir = 1'b0;
        cyc("joh load", 8'h00, 1'b0, 1'b0);
        load = 1'b0;
        for (int i = 0; i < 16; i++) cyc("joh", joh_exp[i], 1'b1, (i == 15));

        // Shift right zero-fill, with a mirrored view mid-run
        load = 1'b1; load_data = 8'h90; mode = 2'b01; dir = 1'b1;
        cyc("shr load", 8'h90, 1'b0, 1'b0);
        load = 1'b0;
        for (int i = 0; i < 7; i++) cyc("shr", shr_exp[i], 1'b1, 1'b0);
        run = 1'b0; mirror = 1'b1;
        #1;
        check("mirror shr", {24'h0, pattern}, 32'h80);
        mirror = 1'b0;

        // Load in a tick cycle wins with no step; reset beats load
        mode = 2'b00; dir = 1'b0; run = 1'b1;
        load = 1'b1; load_data = 8'h5A;
        cyc("load prio", 8'h5A, 1'b0, 1'b0);
        rst = 1'b1; load_data = 8'h33;
        cyc("rst prio", 8'h01, 1'b0, 1'b0);
        rst = 1'b0; load = 1'b0;
        cyc("post rst", 8'h02, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
